// File: rtl/ttt_pkg.sv
// Shared encodings, FSM states and winning-line table for the tic-tac-toe move arbiter.
package ttt_pkg;

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;

    typedef enum logic [1:0] {
        S_TURN  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef logic [3:0] cell_idx_t;

    // Rows, columns, then the two diagonals; cells are row-major 0..8.
    localparam cell_idx_t LINE_TBL [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] cell_at(input logic [17:0] b, input cell_idx_t idx);
        return b[2*idx +: 2];
    endfunction

endpackage

// File: rtl/ttt_move_arbiter_if.sv
// Player-request / board-status bundle between the input logic and the move arbiter.
interface ttt_move_arbiter_if;
    logic        new_game;
    logic        req_x;
    logic [3:0]  cell_x;
    logic        req_o;
    logic [3:0]  cell_o;
    logic        grant_x;
    logic        grant_o;
    logic        reject;
    logic [17:0] board;
    logic        turn;
    logic        busy;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output new_game, req_x, cell_x, req_o, cell_o,
        input  grant_x, grant_o, reject, board, turn, busy, game_over, winner
    );

    modport slave (
        input  new_game, req_x, cell_x, req_o, cell_o,
        output grant_x, grant_o, reject, board, turn, busy, game_over, winner
    );
endinterface

// File: rtl/ttt_win_detect.sv
// Combinational line/full evaluation of a board for a given mark.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  mark,
    output logic        line_hit,
    output logic        board_full
);

    always_comb begin
        line_hit = 1'b0;
        for (int unsigned l = 0; l < NUM_LINES; l++) begin
            if (cell_at(board, LINE_TBL[l][0]) == mark &&
                cell_at(board, LINE_TBL[l][1]) == mark &&
                cell_at(board, LINE_TBL[l][2]) == mark)
                line_hit = 1'b1;
        end
    end

    always_comb begin
        board_full = 1'b1;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (cell_at(board, cell_idx_t'(c)) == EMPTY)
                board_full = 1'b0;
        end
    end

endmodule

// File: rtl/ttt_move_arbiter.sv
// Turn arbiter for the tic-tac-toe board: alternates X/O writes, rejects illegal moves,
// and evaluates win/draw one cycle after each accepted write.
module ttt_move_arbiter
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic               clk,
    input  logic               rstn,
    ttt_move_arbiter_if.slave  bus
);

    state_t      r_state, w_state_nxt;
    logic [17:0] r_board, w_board_nxt;
    logic        r_turn, w_turn_nxt;
    logic [1:0]  r_winner, w_winner_nxt;
    logic        r_grant_x, w_grant_x_nxt;
    logic        r_grant_o, w_grant_o_nxt;
    logic        r_reject, w_reject_nxt;

    logic        w_sel_req;
    cell_idx_t   w_sel_cell;
    logic [1:0]  w_mark;
    logic        w_cell_ok;
    logic        w_line_hit;
    logic        w_board_full;

    // Only the player holding the turn is looked at; the other request is dropped.
    assign w_sel_req  = r_turn ? bus.req_o  : bus.req_x;
    assign w_sel_cell = r_turn ? bus.cell_o : bus.cell_x;
    assign w_mark     = r_turn ? MARK_O     : MARK_X;
    assign w_cell_ok  = (w_sel_cell <= 4'd8) && (cell_at(r_board, w_sel_cell) == EMPTY);

    ttt_win_detect u_win_detect (
        .board      (r_board),
        .mark       (w_mark),
        .line_hit   (w_line_hit),
        .board_full (w_board_full)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_board_nxt   = r_board;
        w_turn_nxt    = r_turn;
        w_winner_nxt  = r_winner;
        w_grant_x_nxt = 1'b0;
        w_grant_o_nxt = 1'b0;
        w_reject_nxt  = 1'b0;
        if (bus.new_game) begin
            w_state_nxt  = S_TURN;
            w_board_nxt  = '0;
            w_turn_nxt   = FIRST_PLAYER;
            w_winner_nxt = WIN_NONE;
        end else begin
            case (r_state)
                S_TURN: begin
                    if (w_sel_req) begin
                        if (w_cell_ok) begin
                            w_board_nxt[2*w_sel_cell +: 2] = w_mark;
                            w_grant_x_nxt = ~r_turn;
                            w_grant_o_nxt = r_turn;
                            w_state_nxt   = S_CHECK;
                        end else begin
                            w_reject_nxt = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_line_hit) begin
                        w_state_nxt  = S_DONE;
                        w_winner_nxt = w_mark;
                    end else if (w_board_full) begin
                        w_state_nxt  = S_DONE;
                        w_winner_nxt = WIN_DRAW;
                    end else begin
                        w_turn_nxt  = ~r_turn;
                        w_state_nxt = S_TURN;
                    end
                end
                S_DONE: ;
                default: w_state_nxt = S_TURN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_TURN;
            r_board   <= '0;
            r_turn    <= FIRST_PLAYER;
            r_winner  <= WIN_NONE;
            r_grant_x <= 1'b0;
            r_grant_o <= 1'b0;
            r_reject  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_board   <= w_board_nxt;
            r_turn    <= w_turn_nxt;
            r_winner  <= w_winner_nxt;
            r_grant_x <= w_grant_x_nxt;
            r_grant_o <= w_grant_o_nxt;
            r_reject  <= w_reject_nxt;
        end
    end

    assign bus.grant_x   = r_grant_x;
    assign bus.grant_o   = r_grant_o;
    assign bus.reject    = r_reject;
    assign bus.board     = r_board;
    assign bus.turn      = r_turn;
    assign bus.busy      = (r_state == S_CHECK);
    assign bus.game_over = (r_state == S_DONE);
    assign bus.winner    = r_winner;

endmodule
